// File: rtl/change_dispenser_pkg.sv
// rtl/change_dispenser_pkg.sv - change codes, FSM encoding and helpers shared by the dispenser
package change_dispenser_pkg;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_ONE  = 2'b01;
    localparam logic [1:0] CHG_TWO  = 2'b10;

    // Queue entry layout: {vend, coins[1:0]}
    localparam int TXN_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DROP     = 3'd1,
        ST_EJECT    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_GAP      = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    // The reserved code 11 dispenses nothing.
    function automatic logic [1:0] chg_coins(input logic [1:0] chg);
        case (chg)
            CHG_NONE: return 2'd0;
            CHG_ONE:  return 2'd1;
            CHG_TWO:  return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dispense_fifo.sv
// rtl/dispense_fifo.sv - transaction queue with full-bypass push and sticky overflow
module dispense_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             w_pop;
    logic             w_push;

    assign empty    = (r_count == '0);
    assign full     = (r_count == DEPTH_C);
    assign head     = r_mem[r_rd_ptr];
    assign overflow = r_overflow;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (push && !w_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - sequences product-release and coin-hopper pulses from queued sales
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int PULSE_LEN   = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       out,
    input  logic [1:0] change,
    input  logic       hopper_ack,
    output logic       product_drop,
    output logic       coin_eject,
    output logic       busy,
    output logic       full,
    output logic       overflow,
    output logic       fault
);

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
    localparam logic [7:0] ACK_LAST   = 8'(ACK_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [7:0]         r_cnt;
    logic [1:0]         r_coins;
    logic [1:0]         w_next_coins;
    logic               r_product_drop;
    logic               r_coin_eject;
    logic               r_fault;
    logic [1:0]         w_in_coins;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [TXN_W-1:0]   w_push_data;
    logic [TXN_W-1:0]   w_head;

    assign w_in_coins  = chg_coins(change);
    assign w_push      = out || (w_in_coins != 2'd0);
    assign w_push_data = {out, w_in_coins};
    assign w_pop       = (r_state == ST_IDLE) && !w_empty;

    dispense_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TXN_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (full),
        .overflow  (overflow)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_coins = r_coins;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_next_coins = w_head[1:0];
                    if (w_head[2])
                        w_next_state = ST_DROP;
                    else if (w_head[1:0] != 2'd0)
                        w_next_state = ST_EJECT;
                end
            end
            ST_DROP: begin
                if (r_cnt == PULSE_LAST)
                    w_next_state = (r_coins != 2'd0) ? ST_EJECT : ST_GAP;
            end
            ST_EJECT: begin
                if (r_cnt == PULSE_LAST)
                    w_next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (hopper_ack) begin
                    w_next_coins = r_coins - 2'd1;
                    w_next_state = (r_coins > 2'd1) ? ST_EJECT : ST_GAP;
                end else if (r_cnt == ACK_LAST) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_GAP:   w_next_state = ST_IDLE;
            ST_FAULT: w_next_state = ST_FAULT;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_coins        <= 2'd0;
            r_cnt          <= 8'd0;
            r_product_drop <= 1'b0;
            r_coin_eject   <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_coins <= w_next_coins;
            if (w_next_state != r_state)
                r_cnt <= 8'd0;
            else if (r_state == ST_DROP || r_state == ST_EJECT || r_state == ST_WAIT_ACK)
                r_cnt <= r_cnt + 8'd1;
            r_product_drop <= (w_next_state == ST_DROP);
            r_coin_eject   <= (w_next_state == ST_EJECT);
            r_fault        <= (w_next_state == ST_FAULT);
        end
    end

    assign product_drop = r_product_drop;
    assign coin_eject   = r_coin_eject;
    assign fault        = r_fault;
    assign busy         = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized and directed bench against a transaction-schedule model
module tb_change_dispenser;

    localparam int PL  = 4;
    localparam int TO  = 16;
    localparam int DEP = 4;
    localparam int NC  = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       out_s = 1'b0;
    logic [1:0] change = 2'b00;
    logic       hopper_ack = 1'b0;
    logic       product_drop, coin_eject, busy, full, overflow, fault;

    change_dispenser #(
        .PULSE_LEN   (PL),
        .ACK_TIMEOUT (TO),
        .DEPTH       (DEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .out          (out_s),
        .change       (change),
        .hopper_ack   (hopper_ack),
        .product_drop (product_drop),
        .coin_eject   (coin_eject),
        .busy         (busy),
        .full         (full),
        .overflow     (overflow),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vend;
        int coins;
    } txn_t;

    txn_t q[$];
    bit   exp_drop [NC];
    bit   exp_ej   [NC];
    bit   ack_at   [NC];
    bit   in_wait  [NC];
    int   c;
    int   free_at;
    int   fault_cyc;
    int   busy_cnt;
    bit   ovf;
    int   fixed_d;
    int   fault_pct;
    int   spur_pct;
    int   n_chk;
    int   n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, c, got, want);
    endtask

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < NC; i++) begin
            exp_drop[i] = 1'b0;
            exp_ej[i]   = 1'b0;
            ack_at[i]   = 1'b0;
            in_wait[i]  = 1'b0;
        end
        c         = 0;
        free_at   = 0;
        fault_cyc = 1 << 30;
        ovf       = 1'b0;
        busy_cnt  = 0;
    endfunction

    function automatic int pick_delay();
        if (fixed_d > 0) return fixed_d;
        if ($urandom_range(99) < fault_pct) return TO + 1;
        return $urandom_range(TO, 1);
    endfunction

    // Lays out the whole service timeline of one transaction starting at cycle p0.
    function automatic void schedule(input txn_t t, input int p0);
        int p = p0;
        int d;
        if (t.vend) begin
            for (int i = 0; i < PL; i++) exp_drop[p + i] = 1'b1;
            p += PL;
        end
        for (int k = 0; k < t.coins; k++) begin
            for (int i = 0; i < PL; i++) exp_ej[p + i] = 1'b1;
            p += PL;
            d = pick_delay();
            if (d > TO) begin
                for (int i = 0; i < TO; i++) in_wait[p + i] = 1'b1;
                fault_cyc = p + TO;
                free_at   = 1 << 30;
                return;
            end
            for (int i = 0; i < d; i++) in_wait[p + i] = 1'b1;
            ack_at[p + d - 1] = 1'b1;
            p += d;
        end
        free_at = p + 1;
    endfunction

    function automatic void model_step(input bit o, input logic [1:0] ch);
        int   n;
        txn_t t;
        if (c >= free_at && c < fault_cyc && q.size() > 0) begin
            t = q.pop_front();
            schedule(t, c + 1);
        end
        n = (ch == 2'b01) ? 1 : (ch == 2'b10) ? 2 : 0;
        if (o || n > 0) begin
            if (q.size() < DEP) q.push_back('{vend: o, coins: n});
            else ovf = 1'b1;
        end
    endfunction

    task automatic cyc(input bit o, input logic [1:0] ch);
        bit exp_busy;
        bit ack;
        @(negedge clk);
        if (c >= NC - 64) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d want<%0d", c, c, NC - 64);
            $fatal(1, "cycle budget exceeded");
        end
        exp_busy = (c < free_at) || (q.size() > 0) || (c >= fault_cyc);
        chk("drop",  product_drop, exp_drop[c]);
        chk("eject", coin_eject,   exp_ej[c]);
        chk("busy",  busy,         exp_busy);
        chk("full",  full,         q.size() == DEP);
        chk("ovf",   overflow,     ovf);
        chk("fault", fault,        c >= fault_cyc);
        if (busy) busy_cnt++;
        model_step(o, ch);
        ack = ack_at[c] || (!in_wait[c] && ($urandom_range(99) < spur_pct));
        out_s      = o;
        change     = ch;
        hopper_ack = ack;
        c++;
    endtask

    task automatic rand_cyc(input int push_pct);
        bit         o;
        logic [1:0] ch;
        o  = ($urandom_range(99) < push_pct) && ($urandom_range(1) == 1);
        ch = ($urandom_range(99) < push_pct) ? 2'($urandom_range(3)) : 2'b00;
        cyc(o, ch);
    endtask

    task automatic drain();
        int k = 0;
        while ((q.size() > 0 || c < free_at) && c < fault_cyc && k < 400) begin
            cyc(1'b0, 2'b00);
            k++;
        end
        chk("drain_bound", k < 400, 1);
        repeat (5) cyc(1'b0, 2'b00);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        out_s      = 1'b0;
        change     = 2'b00;
        hopper_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_drop",  product_drop, 0);
        chk("rst_eject", coin_eject,   0);
        chk("rst_busy",  busy,         0);
        chk("rst_full",  full,         0);
        chk("rst_ovf",   overflow,     0);
        chk("rst_fault", fault,        0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int k;
        n_chk     = 0;
        n_pass    = 0;
        fixed_d   = 0;
        fault_pct = 0;
        spur_pct  = 0;
        model_reset();

        // Vend plus one coin, ack on the second wait cycle.
        do_reset();
        fixed_d = 2;
        cyc(1'b1, 2'b01);
        repeat (20) cyc(1'b0, 2'b00);
        chk("busy_len", busy_cnt, 12);
        fixed_d = 0;

        // Two coins, no product.
        do_reset();
        cyc(1'b0, 2'b10);
        repeat (60) cyc(1'b0, 2'b00);

        // Back-to-back vends overrun the queue.
        do_reset();
        repeat (6) cyc(1'b1, 2'b00);
        drain();
        chk("ovf_burst", overflow, 1);

        // Push coincident with pop while full.
        do_reset();
        repeat (5) cyc(1'b1, 2'b00);
        repeat (2) cyc(1'b0, 2'b00);
        cyc(1'b1, 2'b00);
        cyc(1'b0, 2'b00);
        chk("full_bypass", full, 1);
        drain();
        chk("ovf_bypass", overflow, 0);

        // Missing hopper ack leads to FAULT; queue keeps filling.
        do_reset();
        fixed_d = TO + 1;
        cyc(1'b0, 2'b01);
        repeat (40) cyc(1'b0, 2'b00);
        chk("fault_hold", fault, 1);
        repeat (8) cyc(1'b1, 2'b00);
        repeat (10) cyc(1'b0, 2'b00);
        fixed_d = 0;

        // Randomized traffic with spurious acks and occasional timeouts.
        spur_pct = 15;
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            fault_pct = (ph == 2) ? 4 : 0;
            repeat (1200) rand_cyc((ph == 0) ? 10 : (ph == 1) ? 40 : 70);
            drain();
        end
        spur_pct  = 0;
        fault_pct = 0;

        // Reset in the middle of a coin pulse.
        do_reset();
        cyc(1'b0, 2'b01);
        k = 0;
        while (!coin_eject && k < 20) begin
            cyc(1'b0, 2'b00);
            k++;
        end
        chk("eject_seen", coin_eject, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_eject", coin_eject, 0);
        chk("async_busy",  busy,       0);
        chk("async_full",  full,       0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) cyc(1'b0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
